vid_pattern_gen: RTL and testbench

//  Video timing and test-pattern source for the colour-processing pipeline; drives colour_change input directly.

---
 rtl/vid_pattern_gen.sv | 122 ++++++++++++
 tb/tb_vid_pattern_gen.sv | 125 ++++++++++++
 2 files changed

// File: rtl/vid_pattern_gen.sv
// 1080p-style raster timing and test-pattern source: hsync/vsync/VDE plus 24-bit RGB, all registered.
// Optional PAT_SCROLL_EN: per-frame ramp offset that makes the grey ramp scroll.
module vid_pattern_gen #(
    parameter logic [11:0] H_TOTAL      = 12'd2200,
    parameter logic [11:0] H_SYNC_START = 12'd88,
    parameter logic [11:0] H_SYNC_END   = 12'd131,
    parameter logic [11:0] H_ACT_START  = 12'd280,
    parameter logic [10:0] V_TOTAL      = 11'd1125,
    parameter logic [10:0] V_SYNC_START = 11'd4,
    parameter logic [10:0] V_SYNC_END   = 11'd8,
    parameter logic [10:0] V_ACT_START  = 11'd45,
    parameter logic [7:0]  BAR_W        = 8'd240
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [1:0]  pat_sel,
    input  logic [23:0] solid_rgb,
    output logic [23:0] o_vid_data,
    output logic        o_vid_hsync,
    output logic        o_vid_vsync,
    output logic        o_vid_VDE,
    output logic        o_frame_start
);

    logic [11:0] hcnt_q, hcnt_d;
    logic [10:0] vcnt_q, vcnt_d;
    logic [1:0]  pat_q, pat_d;
    logic [2:0]  bar_idx_q, bar_idx_d;
    logic [7:0]  bar_pix_q, bar_pix_d;
    logic [7:0]  off;
    logic        h_last, v_last, frame_end;
    logic [7:0]  x_lo, ramp;
    logic        y_b5, vde;
    logic [23:0] pix, data_d;

    assign h_last    = (hcnt_q == H_TOTAL - 12'd1);
    assign v_last    = (vcnt_q == V_TOTAL - 11'd1);
    assign frame_end = h_last & v_last;

`ifdef PAT_SCROLL_EN
    logic [7:0] off_q;
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst)          off_q <= 8'd0;
        else if (frame_end) off_q <= off_q + 8'd1;
    end
    assign off = off_q;
`else
    assign off = 8'd0;
`endif

    always_comb begin
        hcnt_d    = h_last ? 12'd0 : hcnt_q + 12'd1;
        vcnt_d    = vcnt_q;
        if (h_last) vcnt_d = v_last ? 11'd0 : vcnt_q + 11'd1;
        pat_d     = frame_end ? pat_sel : pat_q;
        // Bar counter is re-armed one pixel ahead so it reads 0 exactly at x=0.
        bar_idx_d = bar_idx_q;
        bar_pix_d = bar_pix_q + 8'd1;
        if (hcnt_q == H_ACT_START - 12'd1) begin
            bar_idx_d = 3'd0;
            bar_pix_d = 8'd0;
        end else if (bar_pix_q == BAR_W - 8'd1) begin
            bar_idx_d = bar_idx_q + 3'd1;
            bar_pix_d = 8'd0;
        end
    end

    // Only the low bits of the active coordinates are ever needed.
    assign x_lo = hcnt_q[7:0] - H_ACT_START[7:0];
    assign y_b5 = 1'((vcnt_q[5:0] - V_ACT_START[5:0]) >> 5);
    assign ramp = x_lo + off;
    assign vde  = (hcnt_q >= H_ACT_START) && (vcnt_q >= V_ACT_START);

    always_comb begin
        pix = 24'h000000;
        case (pat_q)
            2'd0: begin
                case (bar_idx_q)
                    3'd0:    pix = 24'hFFFFFF;
                    3'd1:    pix = 24'hFFFF00;
                    3'd2:    pix = 24'h00FFFF;
                    3'd3:    pix = 24'h00FF00;
                    3'd4:    pix = 24'hFF00FF;
                    3'd5:    pix = 24'hFF0000;
                    3'd6:    pix = 24'h0000FF;
                    default: pix = 24'h000000;
                endcase
            end
            2'd1:    pix = (x_lo[5] ^ y_b5) ? 24'h000000 : 24'hFFFFFF;
            2'd2:    pix = {ramp, ramp, ramp};
            default: pix = solid_rgb;
        endcase
        data_d = vde ? pix : 24'h000000;
    end

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            hcnt_q        <= 12'd0;
            vcnt_q        <= 11'd0;
            pat_q         <= 2'd0;
            bar_idx_q     <= 3'd0;
            bar_pix_q     <= 8'd0;
            o_vid_data    <= 24'h000000;
            o_vid_hsync   <= 1'b0;
            o_vid_vsync   <= 1'b0;
            o_vid_VDE     <= 1'b0;
            o_frame_start <= 1'b0;
        end else begin
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            pat_q         <= pat_d;
            bar_idx_q     <= bar_idx_d;
            bar_pix_q     <= bar_pix_d;
            o_vid_data    <= data_d;
            o_vid_hsync   <= (hcnt_q >= H_SYNC_START) && (hcnt_q <= H_SYNC_END);
            o_vid_vsync   <= (vcnt_q >= V_SYNC_START) && (vcnt_q <= V_SYNC_END);
            o_vid_VDE     <= vde;
            o_frame_start <= (hcnt_q == 12'd0) && (vcnt_q == 11'd0);
        end
    end

endmodule

// File: tb/tb_vid_pattern_gen.sv
// Scoreboard bench for vid_pattern_gen on a reduced raster (80x50 total, 72x44 active, 9-pixel bars).
// A raster-position model pushes expected outputs every edge; a monitor pops and compares.
module tb_vid_pattern_gen;
    localparam int HT = 80, HSS = 3, HSE = 6, HAS = 8;
    localparam int VT = 50, VSS = 1, VSE = 2, VAS = 6;
    localparam int BW = 9;

    logic        clk = 1'b0;
    logic        n_rst = 1'b1;
    logic [1:0]  pat_sel = 2'd0;
    logic [23:0] solid_rgb = 24'h0;
    logic [23:0] o_vid_data;
    logic        o_vid_hsync, o_vid_vsync, o_vid_VDE, o_frame_start;

    typedef struct {
        logic [23:0] d;
        logic        hs, vs, vde, fs;
    } exp_t;

    exp_t q[$];
    int   errors = 0, checks = 0;
    int   p = 0;
    int   pat_of[int];

    vid_pattern_gen #(
        .H_TOTAL(12'(HT)), .H_SYNC_START(12'(HSS)), .H_SYNC_END(12'(HSE)), .H_ACT_START(12'(HAS)),
        .V_TOTAL(11'(VT)), .V_SYNC_START(11'(VSS)), .V_SYNC_END(11'(VSE)), .V_ACT_START(11'(VAS)),
        .BAR_W(8'(BW))
    ) dut (
        .clk(clk), .n_rst(n_rst), .pat_sel(pat_sel), .solid_rgb(solid_rgb),
        .o_vid_data(o_vid_data), .o_vid_hsync(o_vid_hsync), .o_vid_vsync(o_vid_vsync),
        .o_vid_VDE(o_vid_VDE), .o_frame_start(o_frame_start)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] ref_pix(int x, int y, int pat, int frame, logic [23:0] solid);
        logic [23:0] bars [8];
        logic [7:0]  g;
        int          off;
        bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
`ifdef PAT_SCROLL_EN
        off = frame % 256;
`else
        off = 0;
`endif
        case (pat)
            0:       return bars[x / BW];
            1:       return ((((x / 32) + (y / 32)) % 2) == 1) ? 24'h000000 : 24'hFFFFFF;
            2:       begin g = 8'((x + off) % 256); return {g, g, g}; end
            default: return solid;
        endcase
    endfunction

    // Reference model: position derived from cycles since reset release.
    always @(posedge clk) begin
        exp_t e;
        int h, v, f;
        e = '{24'h0, 1'b0, 1'b0, 1'b0, 1'b0};
        if (n_rst) begin
            p = 0;
            pat_of.delete();
            pat_of[0] = 0;
        end else begin
            h = p % HT;
            v = (p / HT) % VT;
            f = p / (HT * VT);
            e.hs  = (h >= HSS && h <= HSE);
            e.vs  = (v >= VSS && v <= VSE);
            e.vde = (h >= HAS && v >= VAS);
            e.fs  = (h == 0 && v == 0);
            if (e.vde) e.d = ref_pix(h - HAS, v - VAS, pat_of[f], f, solid_rgb);
            if (h == HT - 1 && v == VT - 1) pat_of[f + 1] = int'(pat_sel);
            p++;
        end
        q.push_back(e);
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL sb_empty t=%0t no expected entry", $time);
        end else begin
            e = q.pop_front();
            if (o_vid_data !== e.d) begin
                errors++;
                if (errors <= 20)
                    $display("FAIL data t=%0t got=%h exp=%h", $time, o_vid_data, e.d);
            end
            checks++;
            if ({o_vid_hsync, o_vid_vsync, o_vid_VDE, o_frame_start} !== {e.hs, e.vs, e.vde, e.fs}) begin
                errors++;
                if (errors <= 20)
                    $display("FAIL sync t=%0t got hs/vs/vde/fs=%b exp=%b", $time,
                             {o_vid_hsync, o_vid_vsync, o_vid_VDE, o_frame_start},
                             {e.hs, e.vs, e.vde, e.fs});
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        n_rst = 1'b0;
        for (int f = 0; f < 7; f++) begin
            for (int c = 0; c < HT * VT; c++) begin
                @(negedge clk);
                solid_rgb = 24'($urandom);
                if (c == (VT / 2) * HT + 10) pat_sel = 2'($urandom);
                if (c == (VT - 3) * HT)      pat_sel = (f < 4) ? 2'(f) : 2'($urandom);
                if (f == 5 && c == 30 * HT + 50) begin
                    n_rst = 1'b1;
                    repeat (3) @(negedge clk);
                    n_rst = 1'b0;
                end
            end
        end
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
